// File: rtl/dic_clock_pkg.sv
// Shared types and constants for the digital-clock control FSM and its key decoder.
package dic_clock_pkg;

  typedef enum logic [2:0] {
    STOP,
    RUN,
    SET_MT,
    SET_MO,
    SET_ST,
    SET_SO
  } stateT;

  localparam logic [7:0] KEY_RUN  = 8'h72;  // 'r'
  localparam logic [7:0] KEY_STOP = 8'h70;  // 'p'
  localparam logic [7:0] KEY_SET  = 8'h73;  // 's'
  localparam logic [7:0] KEY_LED  = 8'h6C;  // 'l'
  localparam logic [7:0] KEY_ESC  = 8'h1B;
  localparam logic [7:0] KEY_ZERO = 8'h30;  // '0'
  localparam logic [7:0] KEY_NINE = 8'h39;  // '9'

  localparam logic [3:0] DIGIT_MAX_TENS = 4'd5;
  localparam logic [3:0] DIGIT_MAX_ONES = 4'd9;

  localparam int unsigned SET_TMO_DEF = 10;

  function automatic logic isSetState(stateT s);
    return s inside {SET_MT, SET_MO, SET_ST, SET_SO};
  endfunction

endpackage

// File: rtl/dic_clock_ctrl_if.sv
// Key-receiver inputs and didp-facing outputs of the clock controller, bundled.
interface dic_clock_ctrl_if;
  logic       i_key_vld;
  logic [7:0] i_key;
  logic       i_oneSecStrb;
  logic       dicRun;
  logic       ldMtens;
  logic       ldMones;
  logic       ldStens;
  logic       ldSones;
  logic [3:0] ld_num;
  logic       dicSelectLEDdisp;
  logic       o_setMode;
  logic [1:0] o_ledSel;

  modport master (
    output i_key_vld, i_key, i_oneSecStrb,
    input  dicRun, ldMtens, ldMones, ldStens, ldSones, ld_num,
           dicSelectLEDdisp, o_setMode, o_ledSel
  );

  modport slave (
    input  i_key_vld, i_key, i_oneSecStrb,
    output dicRun, ldMtens, ldMones, ldStens, ldSones, ld_num,
           dicSelectLEDdisp, o_setMode, o_ledSel
  );
endinterface

// File: rtl/dic_key_decode.sv
// Combinational ASCII classifier: command keys and decimal digits (case-sensitive).
module dic_key_decode
  import dic_clock_pkg::*;
(
  input  logic [7:0] key,
  output logic       isRun,
  output logic       isStop,
  output logic       isSet,
  output logic       isLed,
  output logic       isEsc,
  output logic       isDigit,
  output logic [3:0] digit
);

  logic [7:0] keyOffset;

  assign isRun     = (key == KEY_RUN);
  assign isStop    = (key == KEY_STOP);
  assign isSet     = (key == KEY_SET);
  assign isLed     = (key == KEY_LED);
  assign isEsc     = (key == KEY_ESC);
  assign isDigit   = (key >= KEY_ZERO) && (key <= KEY_NINE);
  assign keyOffset = key - KEY_ZERO;
  assign digit     = keyOffset[3:0];

endmodule

// File: rtl/dic_clock_ctrl.sv
// Digital-clock control FSM: run/stop, LED digit stepping and 4-digit set-time entry
// with inactivity timeout. Every output is registered.
module dic_clock_ctrl
  import dic_clock_pkg::*;
#(
  parameter int unsigned SET_TMO = SET_TMO_DEF
) (
  input  logic             clk,
  input  logic             rst,
  dic_clock_ctrl_if.slave  bus
);

  localparam logic [3:0] TMO_LAST = 4'(SET_TMO - 1);

  stateT      state, stateNxt;
  logic       runSave, runSaveNxt;
  logic [3:0] tmoCnt, tmoCntNxt;
  logic [1:0] ledSel, ledSelNxt;
  logic [3:0] ldNum, ldNumNxt;
  logic       dicRun, dicRunNxt;
  logic       setMode, setModeNxt;
  logic       ledStep, ledStepNxt;
  logic [3:0] ldVec, ldVecNxt;  // {Mtens, Mones, Stens, Sones}

  logic       isRun, isStop, isSet, isLed, isEsc, isDigit;
  logic [3:0] digit;
  logic       inSet, keyVld, digitOk, acceptDigit, escReq, tmoHit;
  stateT      exitState;

  dic_key_decode uDecode (
    .key     (bus.i_key),
    .isRun   (isRun),
    .isStop  (isStop),
    .isSet   (isSet),
    .isLed   (isLed),
    .isEsc   (isEsc),
    .isDigit (isDigit),
    .digit   (digit)
  );

  assign keyVld      = bus.i_key_vld;
  assign inSet       = isSetState(state);
  assign digitOk     = (state inside {SET_MT, SET_ST}) ? (digit <= DIGIT_MAX_TENS)
                                                       : (digit <= DIGIT_MAX_ONES);
  assign acceptDigit = inSet && keyVld && isDigit && digitOk;
  assign escReq      = inSet && keyVld && isEsc;
  // An accepted key in the same cycle as the final strobe pre-empts the timeout.
  assign tmoHit      = inSet && bus.i_oneSecStrb && !acceptDigit && !escReq
                       && (tmoCnt == TMO_LAST);
  assign exitState   = runSave ? RUN : STOP;

  // NOTE: reset is synchronous here, so it sits inside the clocked branch; all state uses <=.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= STOP;
      runSave <= 1'b0;
      tmoCnt  <= '0;
      ledSel  <= '0;
      ldNum   <= '0;
      dicRun  <= 1'b0;
      setMode <= 1'b0;
      ledStep <= 1'b0;
      ldVec   <= '0;
    end else begin
      state   <= stateNxt;
      runSave <= runSaveNxt;
      tmoCnt  <= tmoCntNxt;
      ledSel  <= ledSelNxt;
      ldNum   <= ldNumNxt;
      dicRun  <= dicRunNxt;
      setMode <= setModeNxt;
      ledStep <= ledStepNxt;
      ldVec   <= ldVecNxt;
    end
  end

  // NOTE: defaulting every target up front keeps these combinational blocks latch-free.
  always_comb begin
    stateNxt = state;
    unique case (state)
      STOP:    if (keyVld && isRun) stateNxt = RUN;
               else if (keyVld && isSet) stateNxt = SET_MT;
      RUN:     if (keyVld && isStop) stateNxt = STOP;
               else if (keyVld && isSet) stateNxt = SET_MT;
      SET_MT:  if (acceptDigit) stateNxt = SET_MO;
               else if (escReq || tmoHit) stateNxt = exitState;
      SET_MO:  if (acceptDigit) stateNxt = SET_ST;
               else if (escReq || tmoHit) stateNxt = exitState;
      SET_ST:  if (acceptDigit) stateNxt = SET_SO;
               else if (escReq || tmoHit) stateNxt = exitState;
      SET_SO:  if (acceptDigit || escReq || tmoHit) stateNxt = exitState;
      default: stateNxt = STOP;
    endcase
  end

  always_comb begin
    runSaveNxt = runSave;
    tmoCntNxt  = tmoCnt;
    ledSelNxt  = ledSel;
    ldNumNxt   = ldNum;
    ledStepNxt = 1'b0;
    ldVecNxt   = '0;

    if (!inSet && stateNxt == SET_MT) begin
      runSaveNxt = (state == RUN);
      tmoCntNxt  = '0;
    end else if (acceptDigit) begin
      tmoCntNxt = '0;
      ldNumNxt  = digit;
      unique case (state)
        SET_MT:  ldVecNxt = 4'b1000;
        SET_MO:  ldVecNxt = 4'b0100;
        SET_ST:  ldVecNxt = 4'b0010;
        default: ldVecNxt = 4'b0001;
      endcase
    end else if (inSet && bus.i_oneSecStrb) begin
      tmoCntNxt = 4'(tmoCnt + 4'd1);
    end

    if (!isSetState(stateNxt)) tmoCntNxt = '0;

    if (!inSet && keyVld && isLed) begin
      ledStepNxt = 1'b1;
      ledSelNxt  = 2'(ledSel + 2'd1);
    end

    dicRunNxt  = (stateNxt == RUN);
    setModeNxt = isSetState(stateNxt);
  end

  assign bus.dicRun           = dicRun;
  assign bus.ldMtens          = ldVec[3];
  assign bus.ldMones          = ldVec[2];
  assign bus.ldStens          = ldVec[1];
  assign bus.ldSones          = ldVec[0];
  assign bus.ld_num           = ldNum;
  assign bus.dicSelectLEDdisp = ledStep;
  assign bus.o_setMode        = setMode;
  assign bus.o_ledSel         = ledSel;

endmodule

// File: tb/tb_dic_clock_ctrl.sv
// Directed self-checking bench for dic_clock_ctrl: run/stop, set-time entry, timeout, LED stepping.
module tb_dic_clock_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  dic_clock_ctrl_if bus ();

  dic_clock_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [3:0] ldVec;
  assign ldVec = {bus.ldMtens, bus.ldMones, bus.ldStens, bus.ldSones};

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Key presented for one cycle; returns at the negedge where its effect is visible.
  task automatic sendKey(input logic [7:0] k);
    @(negedge clk);
    bus.i_key_vld = 1'b1;
    bus.i_key     = k;
    @(negedge clk);
    bus.i_key_vld = 1'b0;
    bus.i_key     = 8'h00;
  endtask

  task automatic secStrobe();
    @(negedge clk);
    bus.i_oneSecStrb = 1'b1;
    @(negedge clk);
    bus.i_oneSecStrb = 1'b0;
  endtask

  task automatic checkResetVals(input string tag);
    check({tag, "_dicRun"},  {7'd0, bus.dicRun}, 8'd0);
    check({tag, "_ld"},      {4'd0, ldVec}, 8'd0);
    check({tag, "_ldNum"},   {4'd0, bus.ld_num}, 8'd0);
    check({tag, "_ledDisp"}, {7'd0, bus.dicSelectLEDdisp}, 8'd0);
    check({tag, "_setMode"}, {7'd0, bus.o_setMode}, 8'd0);
    check({tag, "_ledSel"},  {6'd0, bus.o_ledSel}, 8'd0);
  endtask

  logic [1:0] expLed [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

  initial begin
    bus.i_key_vld    = 1'b0;
    bus.i_key        = 8'h00;
    bus.i_oneSecStrb = 1'b0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    checkResetVals("reset");

    // 1. run / stop
    sendKey(8'h72);
    check("run_dicRun", {7'd0, bus.dicRun}, 8'd1);
    @(negedge clk);
    bus.i_key = 8'h70;  // stop code without valid strobe must be ignored
    tick();
    bus.i_key = 8'h00;
    check("novld_dicRun", {7'd0, bus.dicRun}, 8'd1);
    sendKey(8'h70);
    check("stop_dicRun", {7'd0, bus.dicRun}, 8'd0);
    sendKey(8'h70);
    check("stop2_dicRun", {7'd0, bus.dicRun}, 8'd0);
    sendKey(8'h52);  // uppercase 'R' ignored
    check("upperR_dicRun", {7'd0, bus.dicRun}, 8'd0);

    // 2. set 47:39 from RUN
    sendKey(8'h72);
    sendKey(8'h73);
    check("set_setMode", {7'd0, bus.o_setMode}, 8'd1);
    check("set_dicRun",  {7'd0, bus.dicRun}, 8'd0);
    sendKey(8'h34);
    check("mt_ld",    {4'd0, ldVec}, 8'h08);
    check("mt_num",   {4'd0, bus.ld_num}, 8'd4);
    check("mt_run",   {7'd0, bus.dicRun}, 8'd0);
    tick();
    check("mt_drop",  {4'd0, ldVec}, 8'h00);
    check("mt_hold",  {4'd0, bus.ld_num}, 8'd4);
    sendKey(8'h37);
    check("mo_ld",    {4'd0, ldVec}, 8'h04);
    check("mo_num",   {4'd0, bus.ld_num}, 8'd7);
    sendKey(8'h33);
    check("st_ld",    {4'd0, ldVec}, 8'h02);
    check("st_num",   {4'd0, bus.ld_num}, 8'd3);
    check("st_run",   {7'd0, bus.dicRun}, 8'd0);
    sendKey(8'h39);
    check("so_ld",    {4'd0, ldVec}, 8'h01);
    check("so_num",   {4'd0, bus.ld_num}, 8'd9);
    check("so_run",   {7'd0, bus.dicRun}, 8'd1);
    check("so_set",   {7'd0, bus.o_setMode}, 8'd0);
    tick();
    check("so_drop",  {4'd0, ldVec}, 8'h00);

    // 3. invalid tens digit from STOP, then valid
    sendKey(8'h70);
    sendKey(8'h73);
    sendKey(8'h36);
    check("inv6_ld",  {4'd0, ldVec}, 8'h00);
    check("inv6_set", {7'd0, bus.o_setMode}, 8'd1);
    sendKey(8'h35);
    check("v5_ld",    {4'd0, ldVec}, 8'h08);
    check("v5_num",   {4'd0, bus.ld_num}, 8'd5);
    sendKey(8'h1B);
    check("esc_stop_run", {7'd0, bus.dicRun}, 8'd0);
    check("esc_stop_set", {7'd0, bus.o_setMode}, 8'd0);

    // 4. timeout after 10 strobes returns to RUN
    sendKey(8'h72);
    sendKey(8'h73);
    sendKey(8'h32);
    check("tmo_ld", {4'd0, ldVec}, 8'h08);
    for (int i = 0; i < 9; i++) secStrobe();
    check("tmo9_set", {7'd0, bus.o_setMode}, 8'd1);
    secStrobe();
    check("tmo10_set", {7'd0, bus.o_setMode}, 8'd0);
    check("tmo10_run", {7'd0, bus.dicRun}, 8'd1);
    check("tmo10_ld",  {4'd0, ldVec}, 8'h00);

    // 5. ESC, then key colliding with 10th strobe
    sendKey(8'h73);
    sendKey(8'h31);
    check("e_ld", {4'd0, ldVec}, 8'h08);
    sendKey(8'h1B);
    check("e_set", {7'd0, bus.o_setMode}, 8'd0);
    check("e_run", {7'd0, bus.dicRun}, 8'd1);
    check("e_ld2", {4'd0, ldVec}, 8'h00);
    sendKey(8'h73);
    for (int i = 0; i < 9; i++) secStrobe();
    @(negedge clk);
    bus.i_key_vld    = 1'b1;
    bus.i_key        = 8'h33;
    bus.i_oneSecStrb = 1'b1;
    @(negedge clk);
    bus.i_key_vld    = 1'b0;
    bus.i_key        = 8'h00;
    bus.i_oneSecStrb = 1'b0;
    check("tie_ld",  {4'd0, ldVec}, 8'h08);
    check("tie_num", {4'd0, bus.ld_num}, 8'd3);
    check("tie_set", {7'd0, bus.o_setMode}, 8'd1);
    secStrobe();
    check("tie_clr_set", {7'd0, bus.o_setMode}, 8'd1);
    sendKey(8'h1B);
    check("tie_esc_run", {7'd0, bus.dicRun}, 8'd1);

    // 6. LED stepping from reset, ignored in SET_ST, reset mid-set
    @(negedge clk);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sendKey(8'h6C);
      check($sformatf("led%0d_pulse", i), {7'd0, bus.dicSelectLEDdisp}, 8'd1);
      check($sformatf("led%0d_sel", i),   {6'd0, bus.o_ledSel}, {6'd0, expLed[i]});
    end
    tick();
    check("led_drop", {7'd0, bus.dicSelectLEDdisp}, 8'd0);
    sendKey(8'h72);
    sendKey(8'h73);
    sendKey(8'h31);
    sendKey(8'h32);
    check("sst_ld", {4'd0, ldVec}, 8'h04);
    sendKey(8'h6C);
    check("sst_led_pulse", {7'd0, bus.dicSelectLEDdisp}, 8'd0);
    check("sst_led_sel",   {6'd0, bus.o_ledSel}, 8'd1);
    check("sst_set",       {7'd0, bus.o_setMode}, 8'd1);
    @(negedge clk);
    rst = 1'b1;
    bus.i_key_vld = 1'b1;
    bus.i_key     = 8'h34;
    @(negedge clk);
    rst = 1'b0;
    bus.i_key_vld = 1'b0;
    bus.i_key     = 8'h00;
    checkResetVals("midrst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
